branch_predictor_table: RTL and testbench

Parametrised branch prediction unit: a direct-mapped table of branch-target entries, each with a saturating direction counter, replacing the single global counter scheme. Fetch looks up the current PC and gets a registered taken/target prediction one cycle later. The execute stage reports resolved branches on the update port; the block trains the table, detects mispredictions and issues a one-cycle redirect with the corrected PC.

---
 rtl/branch_predictor_table.sv | 138 +++++++++++++
 tb/tb_branch_predictor_table.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor_table.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | branch_predictor_table: direct-mapped BTB with per-entry saturating        |
// | direction counters, registered lookup and one-cycle mispredict redirect.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module branch_predictor_table #(
  parameter int XLEN     = 32,
  parameter int ENTRIES  = 64,
  parameter int TAG_BITS = 8,
  parameter int CNT_BITS = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            lookup_valid,
  input  logic [XLEN-1:0] lookup_pc,
  output logic            pred_valid,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            update_valid,
  input  logic [XLEN-1:0] update_pc,
  input  logic            update_is_cond,
  input  logic            update_taken,
  input  logic [XLEN-1:0] update_target,
  input  logic            update_pred_taken,
  input  logic [XLEN-1:0] update_pred_target,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc,
  output logic [31:0]     mispredict_count
);

  localparam int IDX_BITS = $clog2(ENTRIES);
  localparam logic [CNT_BITS-1:0] c_CNT_MAX = '1;
  localparam logic [CNT_BITS-1:0] c_CNT_WT  = CNT_BITS'(1) << (CNT_BITS - 1);
  localparam logic [CNT_BITS-1:0] c_CNT_WNT = c_CNT_WT - CNT_BITS'(1);

  logic [ENTRIES-1:0]                r_valid;
  logic [ENTRIES-1:0]                r_uncond;
  logic [ENTRIES-1:0][TAG_BITS-1:0]  r_tag;
  logic [ENTRIES-1:0][XLEN-1:0]      r_target;
  logic [ENTRIES-1:0][CNT_BITS-1:0]  r_cnt;

  logic [IDX_BITS-1:0] w_lk_idx;
  logic [TAG_BITS-1:0] w_lk_tag;
  logic                w_lk_hit;
  logic                w_lk_taken;
  logic [XLEN-1:0]     w_lk_seq;

  logic [IDX_BITS-1:0] w_up_idx;
  logic [TAG_BITS-1:0] w_up_tag;
  logic                w_up_hit;
  logic [CNT_BITS-1:0] w_cnt_next;
  logic                w_mispredict;
  logic [XLEN-1:0]     w_fix_pc;

  assign w_lk_idx   = lookup_pc[IDX_BITS+1:2];
  assign w_lk_tag   = lookup_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
  assign w_lk_hit   = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
  assign w_lk_taken = w_lk_hit && (r_uncond[w_lk_idx] || r_cnt[w_lk_idx][CNT_BITS-1]);
  assign w_lk_seq   = lookup_pc + XLEN'(4);

  assign w_up_idx = update_pc[IDX_BITS+1:2];
  assign w_up_tag = update_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
  assign w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);

  assign w_mispredict = update_valid &&
                        ((update_taken != update_pred_taken) ||
                         (update_taken && (update_target != update_pred_target)));
  assign w_fix_pc     = update_taken ? update_target : (update_pc + XLEN'(4));

  // Only conditional branches move the direction counter.
  always_comb begin
    w_cnt_next = r_cnt[w_up_idx];
    if (update_is_cond) begin
      if (update_taken && (r_cnt[w_up_idx] != c_CNT_MAX))
        w_cnt_next = r_cnt[w_up_idx] + CNT_BITS'(1);
      else if (!update_taken && (r_cnt[w_up_idx] != '0))
        w_cnt_next = r_cnt[w_up_idx] - CNT_BITS'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid  <= '0;
      r_uncond <= '0;
      r_tag    <= '0;
      r_target <= '0;
      r_cnt    <= {ENTRIES{c_CNT_WNT}};
    end else if (update_valid) begin
      if (w_up_hit) begin
        r_cnt[w_up_idx] <= w_cnt_next;
        if (update_taken) begin
          r_target[w_up_idx] <= update_target;
          r_uncond[w_up_idx] <= !update_is_cond;
        end
      end else if (update_taken) begin
        r_valid[w_up_idx]  <= 1'b1;
        r_tag[w_up_idx]    <= w_up_tag;
        r_target[w_up_idx] <= update_target;
        r_uncond[w_up_idx] <= !update_is_cond;
        r_cnt[w_up_idx]    <= c_CNT_WT;
      end
    end
  end

  // pred_target holds its last value while no lookup is presented.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_valid  <= 1'b0;
      pred_taken  <= 1'b0;
      pred_target <= '0;
    end else if (lookup_valid) begin
      pred_valid  <= 1'b1;
      pred_taken  <= w_lk_taken;
      pred_target <= w_lk_taken ? r_target[w_lk_idx] : w_lk_seq;
    end else begin
      pred_valid  <= 1'b0;
      pred_taken  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect         <= 1'b0;
      redirect_pc      <= '0;
      mispredict_count <= '0;
    end else begin
      redirect <= w_mispredict;
      if (w_mispredict) begin
        redirect_pc <= w_fix_pc;
        if (mispredict_count != 32'hFFFF_FFFF)
          mispredict_count <= mispredict_count + 32'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor_table.sv
`default_nettype none
// Self-checking bench for branch_predictor_table: abstract table model compared
// every cycle, plus directed vectors with hand-computed literal expectations.
module tb_branch_predictor_table;

  localparam int XLEN     = 32;
  localparam int ENTRIES  = 64;
  localparam int TAG_BITS = 8;
  localparam int CNT_BITS = 2;
  localparam int CNT_TOP  = (1 << CNT_BITS) - 1;
  localparam int CNT_HALF = 1 << (CNT_BITS - 1);

  logic            clk = 1'b0;
  logic            rst_n;
  logic            lookup_valid;
  logic [XLEN-1:0] lookup_pc;
  logic            pred_valid;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;
  logic            update_valid;
  logic [XLEN-1:0] update_pc;
  logic            update_is_cond;
  logic            update_taken;
  logic [XLEN-1:0] update_target;
  logic            update_pred_taken;
  logic [XLEN-1:0] update_pred_target;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic [31:0]     mispredict_count;

  int n_checks = 0;
  int n_errors = 0;

  branch_predictor_table #(
    .XLEN(XLEN), .ENTRIES(ENTRIES), .TAG_BITS(TAG_BITS), .CNT_BITS(CNT_BITS)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
    .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_target(pred_target),
    .update_valid(update_valid), .update_pc(update_pc),
    .update_is_cond(update_is_cond), .update_taken(update_taken),
    .update_target(update_target), .update_pred_taken(update_pred_taken),
    .update_pred_target(update_pred_target),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .mispredict_count(mispredict_count)
  );

  always #5 clk = ~clk;

  // Model: table of entries keyed by word index, tag taken from the bits above.
  bit          m_valid  [ENTRIES];
  bit          m_uncond [ENTRIES];
  int unsigned m_tag    [ENTRIES];
  logic [31:0] m_target [ENTRIES];
  int          m_cnt    [ENTRIES];
  logic        e_pv, e_pt, e_rd;
  logic [31:0] e_ptgt, e_rpc, e_cnt;

  function automatic int unsigned idx_of(input logic [31:0] pc);
    return (pc / 4) % ENTRIES;
  endfunction
  function automatic int unsigned tag_of(input logic [31:0] pc);
    return (pc / (4 * ENTRIES)) % (1 << TAG_BITS);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        m_valid[i] = 0; m_uncond[i] = 0; m_tag[i] = 0; m_target[i] = 0;
        m_cnt[i] = CNT_HALF - 1;
      end
      e_pv = 0; e_pt = 0; e_ptgt = 0; e_rd = 0; e_rpc = 0; e_cnt = 0;
    end else begin
      int unsigned li, ui;
      bit hit, tk, mis;
      logic [31:0] seq;
      li = idx_of(lookup_pc);
      ui = idx_of(update_pc);
      if (lookup_valid) begin
        hit = m_valid[li] && (m_tag[li] == tag_of(lookup_pc));
        tk  = hit && (m_uncond[li] || m_cnt[li] >= CNT_HALF);
        seq = lookup_pc + 32'd4;
        e_pv = 1; e_pt = tk; e_ptgt = tk ? m_target[li] : seq;
      end else begin
        e_pv = 0; e_pt = 0;
      end
      mis = update_valid && ((update_taken != update_pred_taken) ||
                             (update_taken && update_target != update_pred_target));
      e_rd = mis;
      if (mis) begin
        seq = update_pc + 32'd4;
        e_rpc = update_taken ? update_target : seq;
        if (e_cnt != 32'hFFFF_FFFF) e_cnt = e_cnt + 1;
      end
      if (update_valid) begin
        hit = m_valid[ui] && (m_tag[ui] == tag_of(update_pc));
        if (hit) begin
          if (update_is_cond) begin
            if (update_taken) m_cnt[ui] = (m_cnt[ui] < CNT_TOP) ? m_cnt[ui] + 1 : CNT_TOP;
            else              m_cnt[ui] = (m_cnt[ui] > 0) ? m_cnt[ui] - 1 : 0;
          end
          if (update_taken) begin
            m_target[ui] = update_target;
            m_uncond[ui] = !update_is_cond;
          end
        end else if (update_taken) begin
          m_valid[ui] = 1; m_tag[ui] = tag_of(update_pc); m_target[ui] = update_target;
          m_uncond[ui] = !update_is_cond; m_cnt[ui] = CNT_HALF;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    chk("pred_valid",  {31'b0, pred_valid}, {31'b0, e_pv});
    chk("pred_taken",  {31'b0, pred_taken}, {31'b0, e_pt});
    chk("pred_target", pred_target, e_ptgt);
    chk("redirect",    {31'b0, redirect}, {31'b0, e_rd});
    chk("redirect_pc", redirect_pc, e_rpc);
    chk("mis_count",   mispredict_count, e_cnt);
  end

  // Pins both the DUT and the model to a hand-computed value.
  task automatic pin(input string name, input logic [31:0] act, input logic [31:0] mdl,
                     input logic [31:0] lit);
    chk(name, act, lit);
    chk({"model_", name}, mdl, lit);
  endtask

  task automatic pin_pred(input logic pt, input logic [31:0] tgt);
    pin("lit_pred_valid", {31'b0, pred_valid}, {31'b0, e_pv}, 32'd1);
    pin("lit_pred_taken", {31'b0, pred_taken}, {31'b0, e_pt}, {31'b0, pt});
    pin("lit_pred_target", pred_target, e_ptgt, tgt);
  endtask

  task automatic pin_rd(input logic rd, input logic [31:0] rpc, input logic [31:0] cnt);
    pin("lit_redirect", {31'b0, redirect}, {31'b0, e_rd}, {31'b0, rd});
    if (rd) pin("lit_redirect_pc", redirect_pc, e_rpc, rpc);
    pin("lit_mis_count", mispredict_count, e_cnt, cnt);
  endtask

  task automatic drive(input bit lv, input logic [31:0] lpc, input bit uv,
                       input logic [31:0] upc, input bit uc, input bit ut,
                       input logic [31:0] utg, input bit upt, input logic [31:0] uptg);
    lookup_valid = lv; lookup_pc = lpc;
    update_valid = uv; update_pc = upc; update_is_cond = uc; update_taken = ut;
    update_target = utg; update_pred_taken = upt; update_pred_target = uptg;
    @(negedge clk);
    lookup_valid = 0; update_valid = 0;
  endtask

  task automatic look(input logic [31:0] pc);
    drive(1, pc, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic upd(input logic [31:0] pc, input bit c, input bit t, input logic [31:0] tg,
                     input bit pt, input logic [31:0] ptg);
    drive(0, 0, 1, pc, c, t, tg, pt, ptg);
  endtask

  initial begin
    rst_n = 0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1;
    pin("lit_rst_pred_valid", {31'b0, pred_valid}, {31'b0, e_pv}, 32'd0);
    pin_rd(0, 0, 0);

    look(32'h100);                   pin_pred(0, 32'h104); pin_rd(0, 0, 0);
    upd(32'h100, 1, 1, 32'h80, 0, 32'h104);               pin_rd(1, 32'h80, 1);
    look(32'h100);                   pin_pred(1, 32'h80);  pin_rd(0, 0, 1);
    upd(32'h100, 1, 0, 0, 1, 32'h80);                     pin_rd(1, 32'h104, 2);
    upd(32'h100, 1, 0, 0, 1, 32'h80);                     pin_rd(1, 32'h104, 3);
    look(32'h100);                   pin_pred(0, 32'h104); pin_rd(0, 0, 3);
    upd(32'h100, 1, 0, 0, 0, 32'h104);                    pin_rd(0, 0, 3);
    look(32'h100);                   pin_pred(0, 32'h104);
    repeat (4) upd(32'h100, 1, 1, 32'h80, 1, 32'h80);     pin_rd(0, 0, 3);
    upd(32'h100, 1, 0, 0, 1, 32'h80);                     pin_rd(1, 32'h104, 4);
    look(32'h100);                   pin_pred(1, 32'h80);

    upd(32'h200, 0, 1, 32'h400, 0, 32'h204);              pin_rd(1, 32'h400, 5);
    upd(32'h200, 1, 0, 0, 1, 32'h400);                    pin_rd(1, 32'h204, 6);
    upd(32'h200, 1, 0, 0, 1, 32'h400);                    pin_rd(1, 32'h204, 7);
    look(32'h200);                   pin_pred(1, 32'h400);
    upd(32'h200, 0, 1, 32'h400, 1, 32'h400);              pin_rd(0, 0, 7);
    look(32'h100);                   pin_pred(0, 32'h104);

    upd(32'h100, 1, 1, 32'h80, 0, 32'h104);               pin_rd(1, 32'h80, 8);
    look(32'h100);                   pin_pred(1, 32'h80);
    upd(32'h200, 1, 1, 32'h900, 0, 32'h204);              pin_rd(1, 32'h900, 9);
    look(32'h100);                   pin_pred(0, 32'h104);
    look(32'h200);                   pin_pred(1, 32'h900);
    upd(32'h200, 1, 1, 32'h900, 1, 32'h904);              pin_rd(1, 32'h900, 10);

    drive(1, 32'h300, 1, 32'h300, 1, 1, 32'h700, 0, 32'h304);
    pin_pred(0, 32'h304); pin_rd(1, 32'h700, 11);
    look(32'h300);                   pin_pred(1, 32'h700);
    drive(1, 32'h300, 1, 32'h300, 1, 1, 32'hA00, 1, 32'h700);
    pin_pred(1, 32'h700); pin_rd(1, 32'hA00, 12);
    look(32'h300);                   pin_pred(1, 32'hA00);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    pin("lit_idle_pred_valid", {31'b0, pred_valid}, {31'b0, e_pv}, 32'd0);
    pin("lit_idle_pred_target", pred_target, e_ptgt, 32'hA00);
    look(32'hFFFF_FFFC);             pin_pred(0, 32'h0);
    look(32'h104);                   pin_pred(0, 32'h108);

    // Asynchronous reset in the middle of a redirect pulse.
    update_valid = 1; update_pc = 32'h300; update_is_cond = 1; update_taken = 1;
    update_target = 32'h50; update_pred_taken = 0; update_pred_target = 32'h304;
    @(posedge clk); #2;
    update_valid = 0;
    pin_rd(1, 32'h50, 13);
    rst_n = 0;
    #1;
    pin("lit_rst_redirect", {31'b0, redirect}, {31'b0, e_rd}, 32'd0);
    pin("lit_rst_redirect_pc", redirect_pc, e_rpc, 32'd0);
    pin("lit_rst_count", mispredict_count, e_cnt, 32'd0);
    pin("lit_rst_pred_target", pred_target, e_ptgt, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    look(32'h300);                   pin_pred(0, 32'h304); pin_rd(0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
